// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared encodings for the accelerator multiply/divide writeback unit
//
// Purpose: operation and FSM state encodings plus the default datapath width,
//          shared by muldiv_wb_unit and muldiv_datapath.
// Contents:
//   DEFAULT_WIDTH  default operand/result width in bits
//   op_e           MUL / MULHU / DIVU / REMU (op[1] selects divide, op[0] selects upper half)
//   state_e        S_IDLE / S_BUSY / S_DONE
package accel_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Divide-class ops run the restoring-subtract step instead of shift-add.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  // MULHU and REMU both read the upper half of the shared accumulator.
  function automatic logic op_is_high(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - one combinational shift-add / restore-subtract iteration
//
// Purpose: computes the next accumulator value for one iteration of either
//          the shift-add multiplier or the restoring divider.
// Ports:
//   is_div_i   1        1 = divide step, 0 = multiply step
//   acc_i      2*WIDTH  current accumulator: {product_hi, product_lo} or {rem, quo}
//   operand_i  WIDTH    multiplicand (multiply) or divisor (divide)
//   acc_o      2*WIDTH  accumulator after this iteration
module muldiv_datapath
  import accel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;

  always_comb begin
    // Multiply: conditionally add into the upper half; the extra bit keeps
    // the carry so the right shift brings it back into the product.
    mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);

    // Divide: {rem, quo} << 1 with the shifted-out remainder bit kept, so the
    // compare sees the full WIDTH+1 bit partial remainder.
    rem_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    // The difference is only used when it is below the divisor, so it fits WIDTH bits.
    rem_diff  = rem_shift[WIDTH-1:0] - operand_i;

    acc_o = '0;
    if (is_div_i) begin
      if (rem_shift >= {1'b0, operand_i}) begin
        acc_o = {rem_diff, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_wb_unit.sv
// rtl/muldiv_wb_unit.sv - iterative unsigned multiply/divide with register-file writeback
//
// Purpose: accepts an operation in IDLE, iterates WIDTH cycles, then pulses a
//          one-cycle write on the register file's second write port.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-low reset
//   start      in   1      issue strobe, sampled only in IDLE
//   op         in   2      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   operand_a  in   WIDTH  multiplicand / dividend
//   operand_b  in   WIDTH  multiplier / divisor
//   dest_reg   in   5      destination register index
//   abort      in   1      synchronous cancel
//   busy       out  1      high in BUSY and DONE
//   wb_en      out  1      one-cycle write enable (RegWrite2)
//   wb_reg     out  5      write index (Write_register2)
//   wb_data    out  WIDTH  write data (Write_data2)
module muldiv_wb_unit
  import accel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [4:0]       dest_reg,
  input  logic             abort,
  output logic             busy,
  output logic             wb_en,
  output logic [4:0]       wb_reg,
  output logic [WIDTH-1:0] wb_data
);

  state_e             state_q;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [4:0]         dest_q;
  logic               busy_q;
  logic               wb_en_q;
  logic [4:0]         wb_reg_q;
  logic [WIDTH-1:0]   wb_data_q;

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .operand_i(operand_q),
    .acc_o    (acc_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      dest_q    <= '0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort wins over a simultaneous start.
          if (start && !abort) begin
            op_q   <= op_e'(op);
            dest_q <= dest_reg;
            cnt_q  <= '0;
            // Only one operand is needed every cycle (multiplicand or divisor);
            // the other seeds the low half of the accumulator (multiplier or
            // dividend) with the upper half cleared.
            if (op[1]) begin
              operand_q <= operand_b;
              acc_q     <= {{WIDTH{1'b0}}, operand_a};
            end else begin
              operand_q <= operand_a;
              acc_q     <= {{WIDTH{1'b0}}, operand_b};
            end
            state_q <= S_BUSY;
            busy_q  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          // wb_reg/wb_data only move when a write actually happens.
          if (!abort && (dest_q != 5'd0)) begin
            wb_en_q   <= 1'b1;
            wb_reg_q  <= dest_q;
            wb_data_q <= op_is_high(op_q) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign wb_en   = wb_en_q;
  assign wb_reg  = wb_reg_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// tb/tb_muldiv_wb_unit.sv - directed self-checking bench for muldiv_wb_unit
module tb_muldiv_wb_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  dest_reg;
  logic        abort;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_wb_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .dest_reg (dest_reg),
    .abort    (abort),
    .busy     (busy),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op at the next edge (T) and checks timing and the writeback.
  // mid: also pulses a different start during BUSY and another around DONE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] exp, input bit mid);
    int early_wb;
    int busy_low;
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
    tick();                                   // edge T
    start = 1'b0;
    chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    early_wb = 0;
    busy_low = 0;
    for (int i = 0; i < 32; i++) begin        // edges T+1 .. T+32
      if (mid && i == 4) begin
        start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd3; dest_reg = 5'd9;
      end
      if (mid && i == 5) start = 1'b0;
      if (mid && i == 31) begin
        start = 1'b1; op = 2'b01; operand_a = 32'hDEAD_BEEF; operand_b = 32'd2; dest_reg = 5'd11;
      end
      tick();
      if (wb_en) early_wb++;
      if (!busy) busy_low++;
    end
    chk({tag, "_no_early_wb"}, early_wb, 32'd0);
    chk({tag, "_busy_held"}, busy_low, 32'd0);
    tick();                                   // edge T+33
    chk({tag, "_wb_en"}, {31'd0, wb_en}, (d != 5'd0) ? 32'd1 : 32'd0);
    chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    if (d != 5'd0) begin
      chk({tag, "_wb_reg"}, {27'd0, wb_reg}, {27'd0, d});
      chk({tag, "_wb_data"}, wb_data, exp);
    end
    start = 1'b0;
    tick();                                   // edge T+34
    chk({tag, "_wb_pulse_end"}, {31'd0, wb_en}, 32'd0);
    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b0; abort = 1'b0;
    start = 1'b1; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    dest_reg = 5'($urandom_range(1, 31));
    tick(); tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    run_op("mul",      2'b00, 32'h0001_0003, 32'h0000_0005, 5'd7, 32'h0005_000F, 1'b0);
    run_op("mulhu",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1'b0);
    run_op("mul_ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0001, 1'b0);
    run_op("divu",     2'b10, 32'd100,       32'd7,         5'd4, 32'd14,        1'b0);
    run_op("remu",     2'b11, 32'd100,       32'd7,         5'd5, 32'd2,         1'b0);
    run_op("divu_z",   2'b10, 32'h1234_5678, 32'd0,         5'd6, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_z",   2'b11, 32'h1234_5678, 32'd0,         5'd8, 32'h1234_5678, 1'b0);
    run_op("ign_start",2'b10, 32'd100,       32'd7,         5'd10,32'd14,        1'b1);

    // Abort at T+10; the restarted op covers the window where the aborted
    // one would have written back, so any stray pulse is caught there.
    start = 1'b1; op = 2'b00; operand_a = 32'd50; operand_b = 32'd50; dest_reg = 5'd12;
    tick();                                   // edge T
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();       // up to T+9
    abort = 1'b1;
    tick();                                   // edge T+10
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_wb_en", {31'd0, wb_en}, 32'd0);
    run_op("after_abort", 2'b11, 32'd1000, 32'd9, 5'd13, 32'd1, 1'b0);

    // abort together with start in IDLE drops the start.
    start = 1'b1; abort = 1'b1; op = 2'b00; operand_a = 32'd1; operand_b = 32'd1; dest_reg = 5'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", {31'd0, busy}, 32'd0);

    // dest 0: same timing, write suppressed, last writeback values retained.
    run_op("dest0", 2'b00, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0);
    chk("dest0_wb_reg_kept", {27'd0, wb_reg}, 32'd13);
    chk("dest0_wb_data_kept", wb_data, 32'd1);

    // Reset mid-operation at T+20.
    start = 1'b1; op = 2'b01; operand_a = 32'hFFFF_0000; operand_b = 32'h0001_0000; dest_reg = 5'd20;
    tick();                                   // edge T
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("midrst_wb_reg", {27'd0, wb_reg}, 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    tick(); tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wb_en || busy) pulses++;
    end
    chk("midrst_no_wb", pulses, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
